// File: rtl/key_debounce_sync_if.sv
// Button-conditioner signal bundle: the raw pin going in and the clean
// level, strobes and press count coming out. The slave side is the
// conditioner itself; the master side is whatever owns the pin and
// consumes the results.
interface key_debounce_sync_if #(
  parameter int COUNT_W = 8
);
  logic               key_raw;
  logic               key_level;
  logic               press_pulse;
  logic               release_pulse;
  logic               repeat_pulse;
  logic [COUNT_W-1:0] press_count;

  modport master (
    output key_raw,
    input  key_level,
    input  press_pulse,
    input  release_pulse,
    input  repeat_pulse,
    input  press_count
  );

  modport slave (
    input  key_raw,
    output key_level,
    output press_pulse,
    output release_pulse,
    output repeat_pulse,
    output press_count
  );
endinterface

// File: rtl/key_debounce_sync.sv
// Push-button conditioner: two-flop synchroniser, debounce FSM, auto-repeat
// timer and a wrapping press counter. Every output comes straight from a
// register, so the PIO and game logic never see combinational glitches.
// The interface COUNT_W must match this module's COUNT_W.
module key_debounce_sync #(
  parameter bit ACTIVE_LOW      = 1'b1,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000,
  parameter int COUNT_W         = 8
) (
  input logic              clk,
  input logic              reset,
  key_debounce_sync_if.slave bus
);

  // Counter widths come from the largest value each counter has to reach,
  // with a floor of one bit so degenerate parameter choices still elaborate.
  localparam int DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;

  localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
  localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);
  localparam bit               REPEAT_EN   = (REPEAT_DELAY != 0);
  localparam logic             PIN_IDLE    = ACTIVE_LOW ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {
    ST_RELEASED,
    ST_PRESS_PEND,
    ST_PRESSED,
    ST_RELEASE_PEND
  } state_t;

  logic               r_sync1;
  logic               r_sync2;
  logic               w_syncP;

  state_t             r_state;
  state_t             w_stateNext;
  logic [DB_W-1:0]    r_dbCnt;
  logic [DB_W-1:0]    w_dbCntNext;
  logic [RPT_W-1:0]   r_rptCnt;
  logic [RPT_W-1:0]   w_rptCntNext;
  logic               r_first;
  logic               w_firstNext;
  logic               r_level;
  logic               w_levelNext;
  logic               r_pressPulse;
  logic               w_pressPulseNext;
  logic               r_releasePulse;
  logic               w_releasePulseNext;
  logic               r_repeatPulse;
  logic               w_repeatPulseNext;
  logic [COUNT_W-1:0] r_pressCount;
  logic [COUNT_W-1:0] w_pressCountNext;

  // Two-flop synchroniser; both stages idle at the released pin level so a
  // reset never looks like a press.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= PIN_IDLE;
      r_sync2 <= PIN_IDLE;
    end else begin
      r_sync1 <= bus.key_raw;
      r_sync2 <= r_sync1;
    end
  end

  assign w_syncP = ACTIVE_LOW ? ~r_sync2 : r_sync2;

  // State register plus every registered output and counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= ST_RELEASED;
      r_dbCnt        <= '0;
      r_rptCnt       <= '0;
      r_first        <= 1'b0;
      r_level        <= 1'b0;
      r_pressPulse   <= 1'b0;
      r_releasePulse <= 1'b0;
      r_repeatPulse  <= 1'b0;
      r_pressCount   <= '0;
    end else begin
      r_state        <= w_stateNext;
      r_dbCnt        <= w_dbCntNext;
      r_rptCnt       <= w_rptCntNext;
      r_first        <= w_firstNext;
      r_level        <= w_levelNext;
      r_pressPulse   <= w_pressPulseNext;
      r_releasePulse <= w_releasePulseNext;
      r_repeatPulse  <= w_repeatPulseNext;
      r_pressCount   <= w_pressCountNext;
    end
  end

  // Debounce decisions and the auto-repeat timer; the repeat counter only
  // advances in PRESSED, so a release bounce pauses it rather than resetting it.
  always_comb begin
    w_stateNext        = r_state;
    w_dbCntNext        = r_dbCnt;
    w_rptCntNext       = r_rptCnt;
    w_firstNext        = r_first;
    w_levelNext        = r_level;
    w_pressPulseNext   = 1'b0;
    w_releasePulseNext = 1'b0;
    w_repeatPulseNext  = 1'b0;
    w_pressCountNext   = r_pressCount;

    case (r_state)
      ST_RELEASED: begin
        if (w_syncP) begin
          w_stateNext = ST_PRESS_PEND;
          w_dbCntNext = '0;
        end
      end
      ST_PRESS_PEND: begin
        if (!w_syncP) begin
          w_stateNext = ST_RELEASED;
        end else if (r_dbCnt == DB_LAST) begin
          w_stateNext      = ST_PRESSED;
          w_levelNext      = 1'b1;
          w_pressPulseNext = 1'b1;
          w_pressCountNext = r_pressCount + COUNT_W'(1);
          w_rptCntNext     = '0;
          w_firstNext      = 1'b1;
        end else begin
          w_dbCntNext = r_dbCnt + DB_W'(1);
        end
      end
      ST_PRESSED: begin
        if (!w_syncP) begin
          w_stateNext = ST_RELEASE_PEND;
          w_dbCntNext = '0;
        end else if (REPEAT_EN) begin
          if (r_rptCnt == (r_first ? DELAY_LAST : PERIOD_LAST)) begin
            w_repeatPulseNext = 1'b1;
            w_rptCntNext      = '0;
            w_firstNext       = 1'b0;
          end else begin
            w_rptCntNext = r_rptCnt + RPT_W'(1);
          end
        end
      end
      ST_RELEASE_PEND: begin
        if (w_syncP) begin
          w_stateNext = ST_PRESSED;
        end else if (r_dbCnt == DB_LAST) begin
          w_stateNext        = ST_RELEASED;
          w_levelNext        = 1'b0;
          w_releasePulseNext = 1'b1;
        end else begin
          w_dbCntNext = r_dbCnt + DB_W'(1);
        end
      end
      default: begin
        w_stateNext = ST_RELEASED;
      end
    endcase
  end

  assign bus.key_level     = r_level;
  assign bus.press_pulse   = r_pressPulse;
  assign bus.release_pulse = r_releasePulse;
  assign bus.repeat_pulse  = r_repeatPulse;
  assign bus.press_count   = r_pressCount;

endmodule
